// File: rtl/vegeta_wt_loader_fp6.sv
// rtl/vegeta_wt_loader_fp6.sv - FP6 VEGETA column weight loader
//
// Purpose: accepts ROWS packed FP6 weight+metadata beats over a valid/ready
// stream and replays each one, registered, into the head of the column's
// weight chain. The first beat accepted therefore ends up in the farthest PU.
// Reports completion with a one-cycle load_done and flips compute_buf to the
// buffer that was just filled.
//
// Optional feature macro: VEGETA_WL_META_CHECK_EN (2:4 metadata order checker).
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   load_start               one-cycle load request, honoured only in IDLE
//   load_buf, gemm_mode      target buffer / sparsity mode, sampled with load_start
//   s_valid, s_ready, s_data weight beat stream
//   weight_out               beat into the first PU of the column
//   weight_transferring_out  chain shift strobe
//   i_wb, compute_buf        load-side and compute-side buffer selects
//   busy, load_done          load in progress / completion pulse
//   meta_err                 sticky metadata violation (0 without the macro)
module vegeta_wt_loader_fp6 #(
  parameter int BETA           = 4,
  parameter int MUL_DATAWIDTH  = 6,
  parameter int META_DATA_SIZE = 2,
  parameter int ROWS           = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         load_start,
  input  logic                                         load_buf,
  input  logic [1:0]                                   gemm_mode,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] s_data,
  output logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
  output logic                                         weight_transferring_out,
  output logic                                         i_wb,
  output logic                                         compute_buf,
  output logic                                         busy,
  output logic                                         load_done,
  output logic                                         meta_err
);

  localparam int LW = MUL_DATAWIDTH + META_DATA_SIZE;
  localparam int DW = BETA * LW;
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            i_wb_q, i_wb_d;
  logic            compute_buf_q, compute_buf_d;
  logic [DW-1:0]   weight_out_q, weight_out_d;
  logic            xfer_q, xfer_d;

  logic start_acc;
  logic accept;

  assign start_acc = (state_q == IDLE) && load_start;
  assign accept    = (state_q == LOAD) && s_valid;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    i_wb_d        = i_wb_q;
    compute_buf_d = compute_buf_q;
    weight_out_d  = weight_out_q;
    xfer_d        = 1'b0;
    s_ready       = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          i_wb_d  = load_buf;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          // Stalled cycles leave weight_out untouched so the PUs see a stable head.
          weight_out_d = s_data;
          xfer_d       = 1'b1;
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        busy          = 1'b1;
        load_done     = 1'b1;
        compute_buf_d = i_wb_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      i_wb_q        <= 1'b0;
      compute_buf_q <= 1'b0;
      weight_out_q  <= '0;
      xfer_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      i_wb_q        <= i_wb_d;
      compute_buf_q <= compute_buf_d;
      weight_out_q  <= weight_out_d;
      xfer_q        <= xfer_d;
    end
  end

  assign weight_out              = weight_out_q;
  assign weight_transferring_out = xfer_q;
  assign i_wb                    = i_wb_q;
  assign compute_buf             = compute_buf_q;

`ifdef VEGETA_WL_META_CHECK_EN
  logic [1:0] mode_q, mode_d;
  logic       meta_err_q, meta_err_d;
  logic       viol;

  // In 2:4 mode each lane pair carries two distinct indices into a group of
  // four, so the upper lane's index must be strictly greater.
  always_comb begin
    viol = 1'b0;
    if (mode_q == 2'd1) begin
      for (int k = 0; k < BETA / 2; k++) begin
        if (s_data[(2*k)*LW + MUL_DATAWIDTH +: META_DATA_SIZE] >=
            s_data[(2*k+1)*LW + MUL_DATAWIDTH +: META_DATA_SIZE])
          viol = 1'b1;
      end
    end
  end

  always_comb begin
    mode_d     = start_acc ? gemm_mode : mode_q;
    meta_err_d = start_acc ? 1'b0 : (meta_err_q | (accept & viol));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 2'd0;
      meta_err_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      meta_err_q <= meta_err_d;
    end
  end

  assign meta_err = meta_err_q;
`else
  logic unused_gemm_mode;
  assign unused_gemm_mode = ^gemm_mode;
  assign meta_err         = 1'b0;
`endif

endmodule

// File: tb/tb_vegeta_wt_loader_fp6.sv
// tb/tb_vegeta_wt_loader_fp6.sv - directed self-checking bench for vegeta_wt_loader_fp6
module tb_vegeta_wt_loader_fp6;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, load_buf, s_valid;
  logic [1:0]    gemm_mode;
  logic [DW-1:0] s_data;
  logic          s_ready, xfer, i_wb, compute_buf, busy, load_done, meta_err;
  logic [DW-1:0] weight_out;

  logic          start1, buf1, valid1;
  logic [DW-1:0] data1;
  logic          ready1, xfer1, i_wb1, cbuf1, busy1, done1, merr1;
  logic [DW-1:0] wout1;

  int checks = 0;
  int failures = 0;
  logic exp_merr;

  always #5 clk = ~clk;

  vegeta_wt_loader_fp6 dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_buf(load_buf),
    .gemm_mode(gemm_mode), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .weight_out(weight_out), .weight_transferring_out(xfer), .i_wb(i_wb),
    .compute_buf(compute_buf), .busy(busy), .load_done(load_done), .meta_err(meta_err)
  );

  vegeta_wt_loader_fp6 #(.ROWS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_start(start1), .load_buf(buf1),
    .gemm_mode(2'd0), .s_valid(valid1), .s_ready(ready1), .s_data(data1),
    .weight_out(wout1), .weight_transferring_out(xfer1), .i_wb(i_wb1),
    .compute_buf(cbuf1), .busy(busy1), .load_done(done1), .meta_err(merr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    chk("beat_strobe", xfer, 1);
    chk("beat_data", weight_out, d);
  endtask

  task automatic start(input logic b, input logic [1:0] m);
    load_start = 1'b1;
    load_buf   = b;
    gemm_mode  = m;
    tick();
    load_start = 1'b0;
    chk("start_ready", s_ready, 1);
    chk("start_iwb", i_wb, b);
    chk("start_busy", busy, 1);
  endtask

  initial begin
`ifdef VEGETA_WL_META_CHECK_EN
    exp_merr = 1'b1;
`else
    exp_merr = 1'b0;
`endif
    rst_n = 1'b0; load_start = 0; load_buf = 0; gemm_mode = 0; s_valid = 0; s_data = '0;
    start1 = 0; buf1 = 0; valid1 = 0; data1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_wout", weight_out, 0);
    chk("rst_xfer", xfer, 0);
    chk("rst_iwb", i_wb, 0);
    chk("rst_cbuf", compute_buf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_merr", meta_err, 0);

    // Back-to-back load into buffer 1
    start(1'b1, 2'd0);
    beat(32'h11111111);
    chk("b2b_nodone1", load_done, 0);
    beat(32'h22222222);
    beat(32'h33333333);
    beat(32'h44444444);
    chk("b2b_done", load_done, 1);
    chk("b2b_ready_done", s_ready, 0);
    chk("b2b_cbuf_pre", compute_buf, 0);
    s_valid = 1'b0;
    tick();
    chk("b2b_cbuf", compute_buf, 1);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_done_low", load_done, 0);
    chk("b2b_xfer_low", xfer, 0);
    chk("b2b_hold", weight_out, 32'h44444444);

    // Stalled load into buffer 0
    start(1'b0, 2'd0);
    beat(32'h11111111);
    s_valid = 1'b0;
    tick();
    chk("stall_xfer1", xfer, 0);
    chk("stall_hold1", weight_out, 32'h11111111);
    tick();
    chk("stall_xfer2", xfer, 0);
    chk("stall_hold2", weight_out, 32'h11111111);
    chk("stall_nodone", load_done, 0);
    beat(32'h22222222);
    beat(32'h33333333);
    chk("stall_nodone2", load_done, 0);
    beat(32'h44444444);
    chk("stall_done", load_done, 1);
    s_valid = 1'b0;
    tick();
    chk("stall_cbuf", compute_buf, 0);

    // load_start ignored mid-load
    start(1'b1, 2'd0);
    beat(32'hA0A0A0A0);
    load_start = 1'b1;
    load_buf   = 1'b0;
    beat(32'hB0B0B0B0);
    load_start = 1'b0;
    chk("ign_iwb", i_wb, 1);
    beat(32'hC0C0C0C0);
    chk("ign_nodone", load_done, 0);
    beat(32'hD0D0D0D0);
    chk("ign_done", load_done, 1);
    s_valid = 1'b0;
    tick();
    chk("ign_cbuf", compute_buf, 1);

    // Asynchronous reset mid-load
    start(1'b1, 2'd0);
    beat(32'h12345678);
    beat(32'h9ABCDEF0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", s_ready, 0);
    chk("arst_wout", weight_out, 0);
    chk("arst_xfer", xfer, 0);
    chk("arst_iwb", i_wb, 0);
    chk("arst_cbuf", compute_buf, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", busy, 0);
    start(1'b1, 2'd0);
    beat(32'h01010101);
    beat(32'h02020202);
    beat(32'h03030303);
    beat(32'h04040404);
    chk("arst_done", load_done, 1);
    s_valid = 1'b0;
    tick();
    chk("arst_cbuf_after", compute_buf, 1);

    // Metadata checker: 2:4 mode, bad pair on beat 2
    start(1'b0, 2'd1);
    beat(32'hC5854505);
    chk("meta_clean", meta_err, 0);
    beat(32'hC58541C1);
    chk("meta_flag", meta_err, exp_merr);
    beat(32'hC5854505);
    beat(32'hC5854505);
    s_valid = 1'b0;
    tick();
    chk("meta_sticky", meta_err, exp_merr);
    start(1'b0, 2'd0);
    chk("meta_clear", meta_err, 0);
    beat(32'hC5854505);
    beat(32'hC58541C1);
    chk("meta_dense", meta_err, 0);
    beat(32'hC5854505);
    beat(32'hC5854505);
    s_valid = 1'b0;
    tick();
    chk("meta_dense_end", meta_err, 0);

    // ROWS=1 instance
    start1 = 1'b1;
    buf1   = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1_ready", ready1, 1);
    valid1 = 1'b1;
    data1  = 32'hA5A5A5A5;
    tick();
    valid1 = 1'b0;
    chk("r1_xfer", xfer1, 1);
    chk("r1_wout", wout1, 32'hA5A5A5A5);
    chk("r1_done", done1, 1);
    tick();
    chk("r1_cbuf", cbuf1, 1);
    chk("r1_xfer_low", xfer1, 0);
    chk("r1_idle", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
